axi_sram_slave: RTL
===================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter ADDR_BASE, default 64'h0000_0000_8000_0000: byte address of memory word 0.
REQ-002 Parameter MEM_WORDS, default 4096: depth in 32-bit words.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 AR channel: axi_ar_id in 4 (txn id); axi_ar_brust in 2 (burst type); axi_ar_len in 8 (beats-1); axi_ar_size in 3 (log2 bytes/beat); axi_ar_addr in 64 (start byte addr); axi_ar_valid in 1; axi_ar_ready out 1.
REQ-006 R channel: axi_r_data out 32; axi_r_valid out 1; axi_r_ready in 1; axi_r_id out 4; axi_r_last out 1; axi_r_resp out 2.
REQ-007 AW channel: axi_aw_id in 4; axi_aw_brust in 2; axi_aw_len in 8; axi_aw_size in 3; axi_aw_addr in 64; axi_aw_valid in 1; axi_aw_ready out 1.
REQ-008 W channel: axi_w_data in 32; axi_w_strb in 4 (byte enables); axi_w_last in 1; axi_w_valid in 1; axi_w_ready out 1.
REQ-009 B channel: axi_b_valid out 1; axi_b_ready in 1; axi_b_resp out 2; axi_b_id out 4.

Function
REQ-010 Read and write paths SHALL be independent FSMs, each one burst outstanding; r_id and b_id SHALL echo the latched ar_id and aw_id.
REQ-011 Read FSM states R_IDLE, R_MEM, R_DATA: axi_ar_ready=1 only in R_IDLE; AR handshake latches id/addr/len/size/brust, beat=0, goes to R_MEM.
REQ-012 R_MEM SHALL issue one SRAM read and go to R_DATA; R_DATA holds r_valid=1 with stable data/resp/last until r_ready; then R_IDLE if beat==len, else advance address, beat+1, go to R_MEM.
REQ-013 Latency: AR handshake at cycle T gives first r_valid at T+2; each later beat 2 cycles after the previous R handshake; r_last=1 only on beat==len.
REQ-014 Write FSM states W_IDLE, W_DATA, W_RESP: axi_aw_ready=1 only in W_IDLE; axi_w_ready=1 only in W_DATA; W data presented before AW waits (no buffering).
REQ-015 Each W handshake SHALL write enabled byte lanes of the addressed word in the same cycle and advance the address; burst ends on w_last or beat==len, then W_RESP.
REQ-016 W_RESP holds b_valid=1 and stable b_resp/b_id until b_ready, then W_IDLE; first b_valid no earlier than 1 cycle after the final W handshake.
REQ-017 Address advance: FIXED (2'b00) unchanged; INCR (2'b01) addr += 1<<size; 64-bit wrap-around allowed, no 4 KiB check.
REQ-018 Word index = (addr-ADDR_BASE)>>2; beat in range iff ADDR_BASE <= addr < ADDR_BASE+4*MEM_WORDS.
REQ-019 Out-of-range beat: resp DECERR (2'b11), r_data=0, write suppressed.
REQ-020 brust 2'b10/2'b11 or size>2: every beat SLVERR (2'b10), r_data=0, no memory access; beat count still len+1.
REQ-021 w_last before beat==len, or beat==len without w_last: burst ends, b_resp SLVERR.
REQ-022 b_resp = worst over burst (DECERR > SLVERR > OKAY 2'b00); per-beat r_resp is not accumulated.
REQ-023 Same-cycle read and write of one word: read returns old data.
REQ-024 Reads return the full aligned word regardless of size; lane selection is the master's job.

Reset
REQ-025 On rst_n low, both FSMs go to IDLE; ar_ready/aw_ready=1 after release; r_valid, w_ready, b_valid, r_last=0; r_data, r_id, r_resp, b_id, b_resp=0.
REQ-026 Reset mid-burst SHALL abandon the burst without a response; memory contents are not reset.

Structure
REQ-027 Shared package axi_pkg: RESP_OKAY/SLVERR/DECERR, BURST_FIXED/INCR, ID/ADDR/DATA/LEN widths.
REQ-028 Sub-module sram_1r1w (MEM_WORDS x 32, registered read port, byte-strobed write port).

Verification
REQ-029 AR id=1 addr=ADDR_BASE len=0 size=2 INCR after writing 32'hDEADBEEF -> r_valid at T+2, data DEADBEEF, r_last=1, r_id=1, resp 0.
REQ-030 AW id=3 len=3 INCR, 4 beats strb 4'hF, then read back -> b_resp 0, b_id=3, four words read back in order, r_last on beat 3 only.
REQ-031 Write strb 4'b0101 data 32'h11223344 over 32'hFFFFFFFF -> read returns 32'hFF22FF44.
REQ-032 AR addr=ADDR_BASE+4*MEM_WORDS-4 len=1 -> beat0 OKAY, beat1 DECERR data 0.
REQ-033 AW len=3 with w_last on beat 1 -> b_resp SLVERR after 2 beats; WRAP read len=1 -> 2 SLVERR beats.
REQ-034 r_ready held low 5 cycles mid-burst, then rst_n pulsed -> r_valid held stable while stalled, 0 after reset, ar_ready=1.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI widths, response/burst encodings, FSM state types and per-beat helpers.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package axi_pkg;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {R_IDLE, R_MEM, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  // Severity merge: DECERR dominates SLVERR, which dominates OKAY.
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
    if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // Response for one beat. The unsigned offset compare also rejects addresses
  // below base, because the subtraction wraps to a huge value.
  function automatic logic [1:0] beat_resp(input logic [ADDR_W-1:0] addr,
                                           input logic [1:0]        burst,
                                           input logic [2:0]        size,
                                           input logic [ADDR_W-1:0] base,
                                           input logic [ADDR_W-1:0] bytes);
    if (burst[1] || size > 3'd2) return RESP_SLVERR;
    if ((addr - base) >= bytes) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  // FIXED keeps the address; INCR steps by the beat size (64-bit wrap allowed).
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [1:0]        burst,
                                                  input logic [2:0]        size);
    if (burst == BURST_INCR) return addr + (64'd1 << size);
    return addr;
  endfunction

endpackage

// File: rtl/sram_1r1w.sv
// sram_1r1w: WORDS x 32 memory, one registered read port and one byte-strobed write port.
// Latency: read data valid the cycle after rd_en; write lands on the enabling edge.
// Backpressure: none; rd_data holds its value until the next rd_en.
// Ports: clk; rd_en/rd_idx/rd_data read port; wr_en/wr_idx/wr_strb/wr_data write port.
module sram_1r1w #(
  parameter int WORDS = 4096,
  parameter int IDX_W = 12
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_strb,
  input  logic [31:0]      wr_data
);

  logic [31:0] mem [WORDS];

  // Read and write share one edge, so a same-cycle read of the written word
  // returns the old contents.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_idx];
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI slave over a 32-bit SRAM with independent single-burst read and write FSMs.
// Latency: first R beat 2 cycles after AR, then 2 cycles per beat; B 1 cycle after the last W.
// Backpressure: R and B hold until ready; AW/AR accepted only when idle, W only inside a burst.
// Ports: clk, rst_n; AXI AR/R/AW/W/B channels (axi_*), 4-bit ids, 64-bit addresses, 32-bit data.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter logic [63:0] ADDR_BASE = 64'h0000_0000_8000_0000,
  parameter int          MEM_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   axi_ar_id,
  input  logic [1:0]        axi_ar_brust,
  input  logic [LEN_W-1:0]  axi_ar_len,
  input  logic [2:0]        axi_ar_size,
  input  logic [ADDR_W-1:0] axi_ar_addr,
  input  logic              axi_ar_valid,
  output logic              axi_ar_ready,
  output logic [DATA_W-1:0] axi_r_data,
  output logic              axi_r_valid,
  input  logic              axi_r_ready,
  output logic [ID_W-1:0]   axi_r_id,
  output logic              axi_r_last,
  output logic [1:0]        axi_r_resp,
  input  logic [ID_W-1:0]   axi_aw_id,
  input  logic [1:0]        axi_aw_brust,
  input  logic [LEN_W-1:0]  axi_aw_len,
  input  logic [2:0]        axi_aw_size,
  input  logic [ADDR_W-1:0] axi_aw_addr,
  input  logic              axi_aw_valid,
  output logic              axi_aw_ready,
  input  logic [DATA_W-1:0] axi_w_data,
  input  logic [STRB_W-1:0] axi_w_strb,
  input  logic              axi_w_last,
  input  logic              axi_w_valid,
  output logic              axi_w_ready,
  output logic              axi_b_valid,
  input  logic              axi_b_ready,
  output logic [1:0]        axi_b_resp,
  output logic [ID_W-1:0]   axi_b_id
);

  localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) << 2;

  // ---------------- read path ----------------
  rd_state_t         rd_state, rd_next;
  logic [ID_W-1:0]   rd_id;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len, rd_beat;
  logic [2:0]        rd_size;
  logic [1:0]        rd_burst;
  logic [1:0]        rd_beat_resp, r_resp_q;
  logic              r_last_q, rd_en;
  logic [IDX_W-1:0]  rd_idx;
  logic [31:0]       sram_rd;

  assign rd_beat_resp = beat_resp(rd_addr, rd_burst, rd_size, ADDR_BASE, MEM_BYTES);
  assign rd_idx       = IDX_W'((rd_addr - ADDR_BASE) >> 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_state <= R_IDLE;
    else        rd_state <= rd_next;
  end

  always_comb begin
    rd_next      = rd_state;
    axi_ar_ready = 1'b0;
    axi_r_valid  = 1'b0;
    rd_en        = 1'b0;
    case (rd_state)
      R_IDLE: begin
        axi_ar_ready = 1'b1;
        if (axi_ar_valid) rd_next = R_MEM;
      end
      R_MEM: begin
        // Error beats never touch the array.
        rd_en   = (rd_beat_resp == RESP_OKAY);
        rd_next = R_DATA;
      end
      R_DATA: begin
        axi_r_valid = 1'b1;
        if (axi_r_ready) rd_next = (rd_beat == rd_len) ? R_IDLE : R_MEM;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_id    <= '0;
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_beat  <= '0;
      rd_size  <= '0;
      rd_burst <= '0;
      r_resp_q <= RESP_OKAY;
      r_last_q <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: if (axi_ar_valid) begin
          rd_id    <= axi_ar_id;
          rd_addr  <= axi_ar_addr;
          rd_len   <= axi_ar_len;
          rd_size  <= axi_ar_size;
          rd_burst <= axi_ar_brust;
          rd_beat  <= '0;
        end
        R_MEM: begin
          r_resp_q <= rd_beat_resp;
          r_last_q <= (rd_beat == rd_len);
        end
        R_DATA: if (axi_r_ready && rd_beat != rd_len) begin
          rd_addr <= next_addr(rd_addr, rd_burst, rd_size);
          rd_beat <= rd_beat + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The SRAM output register holds between reads, so data stays stable while
  // stalled; error beats and idle cycles present zero.
  assign axi_r_data = (axi_r_valid && r_resp_q == RESP_OKAY) ? sram_rd : '0;
  assign axi_r_last = axi_r_valid & r_last_q;
  assign axi_r_resp = r_resp_q;
  assign axi_r_id   = rd_id;

  // ---------------- write path ----------------
  wr_state_t         wr_state, wr_next;
  logic [ID_W-1:0]   wr_id;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0]  wr_len, wr_beat;
  logic [2:0]        wr_size;
  logic [1:0]        wr_burst;
  logic [1:0]        wr_beat_resp, wr_acc, wr_proto;
  logic              wr_en, wr_end;
  logic [IDX_W-1:0]  wr_idx;

  assign wr_beat_resp = beat_resp(wr_addr, wr_burst, wr_size, ADDR_BASE, MEM_BYTES);
  assign wr_idx       = IDX_W'((wr_addr - ADDR_BASE) >> 2);
  assign wr_end       = axi_w_last || (wr_beat == wr_len);
  // A w_last that disagrees with the AW length still closes the burst, but flags it.
  assign wr_proto     = (axi_w_last != (wr_beat == wr_len)) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_state <= W_IDLE;
    else        wr_state <= wr_next;
  end

  always_comb begin
    wr_next      = wr_state;
    axi_aw_ready = 1'b0;
    axi_w_ready  = 1'b0;
    axi_b_valid  = 1'b0;
    wr_en        = 1'b0;
    case (wr_state)
      W_IDLE: begin
        axi_aw_ready = 1'b1;
        if (axi_aw_valid) wr_next = W_DATA;
      end
      W_DATA: begin
        axi_w_ready = 1'b1;
        if (axi_w_valid) begin
          wr_en = (wr_beat_resp == RESP_OKAY);
          if (wr_end) wr_next = W_RESP;
        end
      end
      W_RESP: begin
        axi_b_valid = 1'b1;
        if (axi_b_ready) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_id    <= '0;
      wr_addr  <= '0;
      wr_len   <= '0;
      wr_beat  <= '0;
      wr_size  <= '0;
      wr_burst <= '0;
      wr_acc   <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: if (axi_aw_valid) begin
          wr_id    <= axi_aw_id;
          wr_addr  <= axi_aw_addr;
          wr_len   <= axi_aw_len;
          wr_size  <= axi_aw_size;
          wr_burst <= axi_aw_brust;
          wr_beat  <= '0;
          wr_acc   <= RESP_OKAY;
        end
        W_DATA: if (axi_w_valid) begin
          wr_acc  <= resp_worst(resp_worst(wr_acc, wr_beat_resp), wr_proto);
          wr_addr <= next_addr(wr_addr, wr_burst, wr_size);
          wr_beat <= wr_beat + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign axi_b_resp = wr_acc;
  assign axi_b_id   = wr_id;

  sram_1r1w #(
    .WORDS(MEM_WORDS),
    .IDX_W(IDX_W)
  ) u_sram (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_data (sram_rd),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_strb (axi_w_strb),
    .wr_data (axi_w_data)
  );

endmodule
